// File: rtl/mjpeg_ddr3_writer.sv
// mjpeg_ddr3_writer: packs the MJPEG byte stream into 128-bit words and writes them to DDR3 ping-pong frame slots
module mjpeg_ddr3_writer #(
    parameter logic [27:0] FRAME_BASE0 = 28'h0000000,
    parameter logic [27:0] FRAME_BASE1 = 28'h0100000,
    parameter int          ADDR_STEP   = 8,
    parameter int          MAX_WORDS   = 32768,
    parameter logic [2:0]  CMD_WR      = 3'b000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_frame_start,
    input  logic         i_frame_end,
    input  logic         i_byte_valid,
    input  logic [7:0]   i_byte_data,
    output logic         o_byte_ready,
    output logic [2:0]   o_ddr3_cmd,
    output logic         o_ddr3_cmd_en,
    output logic [27:0]  o_ddr3_addr,
    output logic [127:0] o_ddr3_wr_data,
    output logic         o_ddr3_wr_data_en,
    output logic         o_ddr3_wr_data_end,
    output logic [15:0]  o_ddr3_wr_mask,
    input  logic         i_ddr3_cmd_ready,
    input  logic         i_ddr3_wr_data_rdy,
    output logic         o_frame_done,
    output logic         o_frame_slot,
    output logic [19:0]  o_frame_len,
    output logic         o_frame_ovf,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t         state, state_nx;
    logic           slot, ovf, hold_valid;
    logic [27:0]    base;
    logic [16:0]    word_idx;
    logic [3:0]     byte_cnt;
    logic [19:0]    len;
    logic [127:0]   pack, hold_data;
    logic [15:0]    hold_mask;
    logic           done_slot, done_ovf;
    logic [19:0]    done_len;
    logic           wr_fire, take, full, store, flush_move;

    // Words already written plus the one waiting in hold count against the slot capacity
    assign wr_fire    = hold_valid & i_ddr3_cmd_ready & i_ddr3_wr_data_rdy;
    assign o_byte_ready = (state == RUN) && !(byte_cnt == 4'd15 && hold_valid);
    assign take       = i_byte_valid & o_byte_ready;
    assign full       = ovf || (word_idx + {16'b0, hold_valid}) == MAX_W;
    assign store      = take & ~full;
    assign flush_move = (state == FLUSH) && !hold_valid && byte_cnt != 4'd0 && !ovf;

    assign o_ddr3_cmd         = CMD_WR;
    assign o_ddr3_cmd_en      = wr_fire;
    assign o_ddr3_wr_data_en  = wr_fire;
    assign o_ddr3_wr_data_end = wr_fire;
    assign o_ddr3_addr        = base + 28'(word_idx) * 28'(ADDR_STEP);
    assign o_ddr3_wr_data     = hold_data;
    assign o_ddr3_wr_mask     = hold_mask;
    assign o_frame_done       = (state == DONE);
    assign o_frame_slot       = (state == DONE) ? slot : done_slot;
    assign o_frame_len        = (state == DONE) ? len : done_len;
    assign o_frame_ovf        = (state == DONE) ? ovf : done_ovf;
    assign o_busy             = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; FLUSH leaves only once the partial word has been pushed out
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_frame_start ? RUN : IDLE;
            RUN:     state_nx = i_frame_end ? FLUSH : RUN;
            FLUSH:   state_nx = (!hold_valid && (byte_cnt == 4'd0 || ovf)) ? DONE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    // Byte packing, hold register, write bookkeeping and frame reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= 1'b0;
            base       <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            len        <= '0;
            ovf        <= 1'b0;
            pack       <= '0;
            hold_data  <= '0;
            hold_mask  <= '0;
            hold_valid <= 1'b0;
            done_slot  <= 1'b0;
            done_len   <= '0;
            done_ovf   <= 1'b0;
        end else begin
            if (state == IDLE && i_frame_start) begin
                base     <= slot ? FRAME_BASE1 : FRAME_BASE0;
                word_idx <= '0;
                byte_cnt <= '0;
                len      <= '0;
                ovf      <= 1'b0;
            end
            if (wr_fire) begin
                hold_valid <= 1'b0;
                word_idx   <= word_idx + 17'd1;
            end
            if (take && full) ovf <= 1'b1;
            if (store) begin
                len      <= len + 20'd1;
                byte_cnt <= byte_cnt + 4'd1;
                if (byte_cnt == 4'd15) begin
                    hold_data  <= {pack[127:8], i_byte_data};
                    hold_mask  <= '0;
                    hold_valid <= 1'b1;
                end else if (byte_cnt == 4'd0) begin
                    pack <= {i_byte_data, 120'b0};
                end else begin
                    pack[127 - {byte_cnt, 3'b000} -: 8] <= i_byte_data;
                end
            end
            if (flush_move) begin
                hold_data  <= pack;
                hold_mask  <= 16'hFFFF >> byte_cnt;
                hold_valid <= 1'b1;
                byte_cnt   <= '0;
            end
            if (state == DONE) begin
                done_slot <= slot;
                done_len  <= len;
                done_ovf  <= ovf;
                slot      <= ~slot;
            end
        end
    end
endmodule

// File: tb/tb_mjpeg_ddr3_writer.sv
// tb_mjpeg_ddr3_writer: directed table-driven bench for the DDR3 frame writer
module tb_mjpeg_ddr3_writer;
    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    always #5 clk = ~clk;

    logic fs = 0, fe = 0, bv = 0, cmd_rdy = 1, dat_rdy = 1, sel = 0;
    logic [7:0] bd = 0;

    logic rdy1, cen1, wen1, wend1, done1, slot1, ovf1, busy1;
    logic [2:0] cmd1;
    logic [27:0] addr1;
    logic [127:0] wd1;
    logic [15:0] wm1;
    logic [19:0] len1;

    logic rdy2, cen2, wen2, wend2, done2, slot2, ovf2, busy2;
    logic [2:0] cmd2;
    logic [27:0] addr2;
    logic [127:0] wd2;
    logic [15:0] wm2;
    logic [19:0] len2;

    wire rdy = sel ? rdy2 : rdy1;

    mjpeg_ddr3_writer dut (
        .clk(clk), .rst(rst), .i_frame_start(fs), .i_frame_end(fe),
        .i_byte_valid(bv), .i_byte_data(bd), .o_byte_ready(rdy1),
        .o_ddr3_cmd(cmd1), .o_ddr3_cmd_en(cen1), .o_ddr3_addr(addr1),
        .o_ddr3_wr_data(wd1), .o_ddr3_wr_data_en(wen1), .o_ddr3_wr_data_end(wend1),
        .o_ddr3_wr_mask(wm1), .i_ddr3_cmd_ready(cmd_rdy), .i_ddr3_wr_data_rdy(dat_rdy),
        .o_frame_done(done1), .o_frame_slot(slot1), .o_frame_len(len1),
        .o_frame_ovf(ovf1), .o_busy(busy1)
    );

    mjpeg_ddr3_writer #(.MAX_WORDS(2)) dut_small (
        .clk(clk), .rst(rst2), .i_frame_start(fs), .i_frame_end(fe),
        .i_byte_valid(bv), .i_byte_data(bd), .o_byte_ready(rdy2),
        .o_ddr3_cmd(cmd2), .o_ddr3_cmd_en(cen2), .o_ddr3_addr(addr2),
        .o_ddr3_wr_data(wd2), .o_ddr3_wr_data_en(wen2), .o_ddr3_wr_data_end(wend2),
        .o_ddr3_wr_mask(wm2), .i_ddr3_cmd_ready(cmd_rdy), .i_ddr3_wr_data_rdy(dat_rdy),
        .o_frame_done(done2), .o_frame_slot(slot2), .o_frame_len(len2),
        .o_frame_ovf(ovf2), .o_busy(busy2)
    );

    typedef struct {
        logic [27:0]  a;
        logic [127:0] d;
        logic [15:0]  m;
        logic [1:0]   s;
    } wr_t;

    typedef struct {
        int          n;
        logic [7:0]  first;
        logic        slot;
        int          exp_len;
        int          exp_wr;
        logic [15:0] exp_mask;
    } frame_t;

    wr_t wq[$];
    frame_t tbl[6];
    int total = 0, bad = 0;
    int acc = 0, acc2 = 0, wr2 = 0, done_cnt = 0, done_cnt2 = 0;
    logic dslot = 0, dovf = 0, d2slot = 0, d2ovf = 0;
    logic [19:0] dlen = 0, d2len = 0;

    // Observe both DUTs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (cen1) wq.push_back('{addr1, wd1, wm1, {wen1, wend1}});
        if (cen2) wr2++;
        if (bv && rdy1) acc++;
        if (bv && rdy2) acc2++;
        if (done1) begin done_cnt++; dslot = slot1; dlen = len1; dovf = ovf1; end
        if (done2) begin done_cnt2++; d2slot = slot2; d2len = len2; d2ovf = ovf2; end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame;
        fs = 1;
        tick;
        fs = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        bv = 1; bd = d; fe = last; t = 0;
        @(negedge clk);
        while (!rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL byte_timeout: byte %0h never accepted", d);
        end
        tick;
        bv = 0; fe = 0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] first);
        start_frame;
        for (int i = 0; i < n; i++) send_byte(8'(first + i), i == n - 1);
        if (n == 0) begin
            fe = 1;
            tick;
            fe = 0;
        end
    endtask

    task automatic wait_done(input int prev);
        int t;
        t = 0;
        while (done_cnt == prev && t < 500) begin
            tick;
            t++;
        end
        chk("done_seen", done_cnt, prev + 1);
    endtask

    task automatic check_frame(input int n, input logic [7:0] first, input logic [27:0] base,
                               input logic exp_slot, input int exp_len, input int exp_wr,
                               input logic [15:0] exp_mask, input int prev);
        wr_t e;
        logic [127:0] d;
        logic [15:0] m;
        wait_done(prev);
        chk("n_writes", wq.size(), exp_wr);
        for (int w = 0; w < exp_wr && wq.size() > 0; w++) begin
            e = wq.pop_front();
            d = '0;
            m = '0;
            for (int k = 0; k < 16; k++) begin
                if (16 * w + k < n) d[127 - 8 * k -: 8] = 8'(first + 16 * w + k);
                else m[15 - k] = 1'b1;
            end
            chk("wr_addr", e.a, base + 28'(8 * w));
            chk("wr_data", e.d, d);
            chk("wr_mask", e.m, m);
            chk("wr_strobes", e.s, 2'b11);
            if (w == exp_wr - 1) chk("last_mask", e.m, exp_mask);
        end
        chk("done_slot", dslot, exp_slot);
        chk("done_len", dlen, exp_len);
        chk("done_ovf", dovf, 1'b0);
        wq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, t;
        tbl[0] = '{32, 8'h00, 1'b0, 32, 2, 16'h0000};
        tbl[1] = '{20, 8'h40, 1'b1, 20, 2, 16'h0FFF};
        tbl[2] = '{17, 8'h60, 1'b0, 17, 2, 16'h7FFF};
        tbl[3] = '{16, 8'h90, 1'b1, 16, 1, 16'h0000};
        tbl[4] = '{1,  8'hA5, 1'b0, 1,  1, 16'h7FFF};
        tbl[5] = '{0,  8'h00, 1'b1, 0,  0, 16'h0000};

        repeat (3) tick;
        @(negedge clk);
        chk("rst_ready", rdy1, 1'b0);
        chk("rst_cmd", cmd1, 3'b000);
        chk("rst_cmd_en", cen1, 1'b0);
        chk("rst_wr_en", {wen1, wend1}, 2'b00);
        chk("rst_addr", addr1, 28'h0);
        chk("rst_data", wd1, 128'h0);
        chk("rst_mask", wm1, 16'h0);
        chk("rst_done", done1, 1'b0);
        chk("rst_frame", {slot1, len1, ovf1}, 22'h0);
        chk("rst_busy", busy1, 1'b0);
        rst = 0;
        tick;

        // frame end in idle must be ignored
        fe = 1;
        tick;
        fe = 0;
        tick;
        chk("idle_end_busy", busy1, 1'b0);
        chk("idle_end_done", done_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            p = done_cnt;
            send_frame(tbl[i].n, tbl[i].first);
            check_frame(tbl[i].n, tbl[i].first, tbl[i].slot ? 28'h0100000 : 28'h0000000,
                        tbl[i].slot, tbl[i].exp_len, tbl[i].exp_wr, tbl[i].exp_mask, p);
        end

        // command channel stalled across a 64-byte frame
        cmd_rdy = 0;
        p = done_cnt;
        acc = 0;
        wq.delete();
        fork
            send_frame(64, 8'h80);
            begin
                repeat (50) @(negedge clk);
                #2;
                chk("stall_accepted", acc, 31);
                chk("stall_writes", wq.size(), 0);
                chk("stall_ready", rdy1, 1'b0);
                @(posedge clk);
                #1;
                cmd_rdy = 1;
            end
        join
        check_frame(64, 8'h80, 28'h0000000, 1'b0, 64, 4, 16'h0000, p);
        chk("stall_total_acc", acc, 64);

        // reset mid-frame: no write, no done, slot back to 0
        p = done_cnt;
        start_frame;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i), 1'b0);
        rst = 1;
        tick;
        tick;
        rst = 0;
        chk("abort_busy", busy1, 1'b0);
        repeat (20) tick;
        chk("abort_writes", wq.size(), 0);
        chk("abort_done", done_cnt, p);
        send_frame(5, 8'hC0);
        check_frame(5, 8'hC0, 28'h0000000, 1'b0, 5, 1, 16'h07FF, p);

        // overflow on the two-word instance
        sel = 1;
        rst2 = 0;
        tick;
        p = done_cnt2;
        acc2 = 0;
        wr2 = 0;
        send_frame(40, 8'h10);
        t = 0;
        while (done_cnt2 == p && t < 500) begin
            tick;
            t++;
        end
        chk("ovf_done_seen", done_cnt2, p + 1);
        chk("ovf_writes", wr2, 2);
        chk("ovf_len", d2len, 32);
        chk("ovf_flag", d2ovf, 1'b1);
        chk("ovf_slot", d2slot, 1'b0);
        chk("ovf_accepted", acc2, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
